// File: rtl/zap_wb_arb_if.sv
// Bus bundle between the TLB/cache next-cycle request ports, the shared
// Wishbone master port and the per-master acknowledge/read-data returns.
// The arbiter uses the master modport; the environment uses the slave modport.
interface zap_wb_arb_if;
  // TLB page-walk requests (next-cycle values)
  logic        i_tlb_wb_cyc_nxt;
  logic        i_tlb_wb_stb_nxt;
  logic        i_tlb_wb_wen_nxt;
  logic [31:0] i_tlb_wb_adr_nxt;
  logic [3:0]  i_tlb_wb_sel_nxt;
  logic [31:0] i_tlb_wb_dat_nxt;
  // Cache line-fill/writeback requests (next-cycle values)
  logic        i_cache_wb_cyc_nxt;
  logic        i_cache_wb_stb_nxt;
  logic        i_cache_wb_wen_nxt;
  logic [31:0] i_cache_wb_adr_nxt;
  logic [3:0]  i_cache_wb_sel_nxt;
  logic [31:0] i_cache_wb_dat_nxt;
  logic [2:0]  i_cache_wb_cti_nxt;
  // Shared Wishbone port
  logic        o_wb_cyc;
  logic        o_wb_stb;
  logic        o_wb_wen;
  logic [31:0] o_wb_adr;
  logic [3:0]  o_wb_sel;
  logic [31:0] o_wb_dat;
  logic [2:0]  o_wb_cti;
  logic        i_wb_ack;
  logic [31:0] i_wb_dat;
  // Per-master returns and owner status
  logic        o_tlb_wb_ack;
  logic        o_cache_wb_ack;
  logic [31:0] o_tlb_wb_dat;
  logic [31:0] o_cache_wb_dat;
  logic [1:0]  o_owner;

  modport master (
    input  i_tlb_wb_cyc_nxt, i_tlb_wb_stb_nxt, i_tlb_wb_wen_nxt,
    input  i_tlb_wb_adr_nxt, i_tlb_wb_sel_nxt, i_tlb_wb_dat_nxt,
    input  i_cache_wb_cyc_nxt, i_cache_wb_stb_nxt, i_cache_wb_wen_nxt,
    input  i_cache_wb_adr_nxt, i_cache_wb_sel_nxt, i_cache_wb_dat_nxt,
    input  i_cache_wb_cti_nxt,
    output o_wb_cyc, o_wb_stb, o_wb_wen, o_wb_adr, o_wb_sel, o_wb_dat, o_wb_cti,
    input  i_wb_ack, i_wb_dat,
    output o_tlb_wb_ack, o_cache_wb_ack, o_tlb_wb_dat, o_cache_wb_dat,
    output o_owner
  );

  modport slave (
    output i_tlb_wb_cyc_nxt, i_tlb_wb_stb_nxt, i_tlb_wb_wen_nxt,
    output i_tlb_wb_adr_nxt, i_tlb_wb_sel_nxt, i_tlb_wb_dat_nxt,
    output i_cache_wb_cyc_nxt, i_cache_wb_stb_nxt, i_cache_wb_wen_nxt,
    output i_cache_wb_adr_nxt, i_cache_wb_sel_nxt, i_cache_wb_dat_nxt,
    output i_cache_wb_cti_nxt,
    input  o_wb_cyc, o_wb_stb, o_wb_wen, o_wb_adr, o_wb_sel, o_wb_dat, o_wb_cti,
    output i_wb_ack, i_wb_dat,
    input  o_tlb_wb_ack, o_cache_wb_ack, o_tlb_wb_dat, o_cache_wb_dat,
    input  o_owner
  );
endinterface

// File: rtl/zap_wb_arb.sv
// Two-master Wishbone arbiter: TLB walker and cache share one bus port.
// TLB wins contention until it has taken FAIR_LIMIT contended grants in a
// row, then the cache gets one. Owners keep the bus while their cyc_nxt is
// high, and every release passes through at least one IDLE cycle.
module zap_wb_arb #(
  parameter int FAIR_LIMIT = 4
) (
  input logic          i_clk,
  input logic          i_reset,
  zap_wb_arb_if.master bus
);

  localparam logic [3:0] FAIR_LIM_C = 4'(FAIR_LIMIT);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    TLB   = 2'b01,
    CACHE = 2'b10
  } state_t;

  state_t      state_r, state_nxt_s;
  logic [3:0]  fair_cnt_r, fair_cnt_nxt_s;
  logic        load_tlb_s, load_cache_s, load_idle_s;

  logic        wb_cyc_r, wb_stb_r, wb_wen_r;
  logic [31:0] wb_adr_r, wb_dat_r;
  logic [3:0]  wb_sel_r;
  logic [2:0]  wb_cti_r;

  logic        wb_cyc_nxt_s, wb_stb_nxt_s, wb_wen_nxt_s;
  logic [31:0] wb_adr_nxt_s, wb_dat_nxt_s;
  logic [3:0]  wb_sel_nxt_s;
  logic [2:0]  wb_cti_nxt_s;

  // Arbitration: next owner, fairness count and which source loads the bus
  always_comb begin
    state_nxt_s    = state_r;
    fair_cnt_nxt_s = fair_cnt_r;
    load_tlb_s     = 1'b0;
    load_cache_s   = 1'b0;
    load_idle_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.i_tlb_wb_cyc_nxt && bus.i_cache_wb_cyc_nxt) begin
          if (fair_cnt_r == FAIR_LIM_C) begin
            state_nxt_s    = CACHE;
            fair_cnt_nxt_s = 4'd0;
            load_cache_s   = 1'b1;
          end else begin
            state_nxt_s    = TLB;
            fair_cnt_nxt_s = fair_cnt_r + 4'd1;
            load_tlb_s     = 1'b1;
          end
        end else if (bus.i_tlb_wb_cyc_nxt) begin
          state_nxt_s = TLB;
          load_tlb_s  = 1'b1;
        end else if (bus.i_cache_wb_cyc_nxt) begin
          state_nxt_s    = CACHE;
          fair_cnt_nxt_s = 4'd0;
          load_cache_s   = 1'b1;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      TLB: begin
        if (bus.i_tlb_wb_cyc_nxt) begin
          load_tlb_s = 1'b1;
        end else begin
          state_nxt_s = IDLE;
          load_idle_s = 1'b1;
        end
      end
      CACHE: begin
        if (bus.i_cache_wb_cyc_nxt) begin
          load_cache_s = 1'b1;
        end else begin
          state_nxt_s = IDLE;
          load_idle_s = 1'b1;
        end
      end
      default: begin
        state_nxt_s = IDLE;
        load_idle_s = 1'b1;
      end
    endcase
  end

  // Bus register next values from the selected source; address/data hold on release
  always_comb begin
    wb_cyc_nxt_s = wb_cyc_r;
    wb_stb_nxt_s = wb_stb_r;
    wb_wen_nxt_s = wb_wen_r;
    wb_adr_nxt_s = wb_adr_r;
    wb_sel_nxt_s = wb_sel_r;
    wb_dat_nxt_s = wb_dat_r;
    wb_cti_nxt_s = wb_cti_r;
    if (load_tlb_s) begin
      wb_cyc_nxt_s = bus.i_tlb_wb_cyc_nxt;
      wb_stb_nxt_s = bus.i_tlb_wb_stb_nxt;
      wb_wen_nxt_s = bus.i_tlb_wb_wen_nxt;
      wb_adr_nxt_s = bus.i_tlb_wb_adr_nxt;
      wb_sel_nxt_s = bus.i_tlb_wb_sel_nxt;
      wb_dat_nxt_s = bus.i_tlb_wb_dat_nxt;
      wb_cti_nxt_s = 3'b111;
    end else if (load_cache_s) begin
      wb_cyc_nxt_s = bus.i_cache_wb_cyc_nxt;
      wb_stb_nxt_s = bus.i_cache_wb_stb_nxt;
      wb_wen_nxt_s = bus.i_cache_wb_wen_nxt;
      wb_adr_nxt_s = bus.i_cache_wb_adr_nxt;
      wb_sel_nxt_s = bus.i_cache_wb_sel_nxt;
      wb_dat_nxt_s = bus.i_cache_wb_dat_nxt;
      wb_cti_nxt_s = bus.i_cache_wb_cti_nxt;
    end else if (load_idle_s) begin
      wb_cyc_nxt_s = 1'b0;
      wb_stb_nxt_s = 1'b0;
      wb_wen_nxt_s = 1'b0;
      wb_sel_nxt_s = 4'h0;
      wb_cti_nxt_s = 3'b111;
    end else begin
      wb_cyc_nxt_s = wb_cyc_r;
    end
  end

  // State, fairness counter and bus registers; reset aborts any transfer at once
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_r    <= IDLE;
      fair_cnt_r <= 4'd0;
      wb_cyc_r   <= 1'b0;
      wb_stb_r   <= 1'b0;
      wb_wen_r   <= 1'b0;
      wb_adr_r   <= 32'h0;
      wb_sel_r   <= 4'h0;
      wb_dat_r   <= 32'h0;
      wb_cti_r   <= 3'b111;
    end else begin
      state_r    <= state_nxt_s;
      fair_cnt_r <= fair_cnt_nxt_s;
      wb_cyc_r   <= wb_cyc_nxt_s;
      wb_stb_r   <= wb_stb_nxt_s;
      wb_wen_r   <= wb_wen_nxt_s;
      wb_adr_r   <= wb_adr_nxt_s;
      wb_sel_r   <= wb_sel_nxt_s;
      wb_dat_r   <= wb_dat_nxt_s;
      wb_cti_r   <= wb_cti_nxt_s;
    end
  end

  assign bus.o_wb_cyc = wb_cyc_r;
  assign bus.o_wb_stb = wb_stb_r;
  assign bus.o_wb_wen = wb_wen_r;
  assign bus.o_wb_adr = wb_adr_r;
  assign bus.o_wb_sel = wb_sel_r;
  assign bus.o_wb_dat = wb_dat_r;
  assign bus.o_wb_cti = wb_cti_r;
  assign bus.o_owner  = state_r;

  // Acks reach only the current owner, and only while a strobe is out
  assign bus.o_tlb_wb_ack   = bus.i_wb_ack & (state_r == TLB)   & wb_stb_r;
  assign bus.o_cache_wb_ack = bus.i_wb_ack & (state_r == CACHE) & wb_stb_r;
  assign bus.o_tlb_wb_dat   = bus.i_wb_dat;
  assign bus.o_cache_wb_dat = bus.i_wb_dat;

endmodule

// File: tb/tb_zap_wb_arb.sv
// Directed bench for zap_wb_arb with FAIR_LIMIT=4.
module tb_zap_wb_arb;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  zap_wb_arb_if bus();

  zap_wb_arb #(.FAIR_LIMIT(4)) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    bus.i_tlb_wb_cyc_nxt   = 1'b0; bus.i_tlb_wb_stb_nxt   = 1'b0; bus.i_tlb_wb_wen_nxt = 1'b0;
    bus.i_tlb_wb_adr_nxt   = 32'h0; bus.i_tlb_wb_sel_nxt  = 4'h0; bus.i_tlb_wb_dat_nxt = 32'h0;
    bus.i_cache_wb_cyc_nxt = 1'b0; bus.i_cache_wb_stb_nxt = 1'b0; bus.i_cache_wb_wen_nxt = 1'b0;
    bus.i_cache_wb_adr_nxt = 32'h0; bus.i_cache_wb_sel_nxt = 4'h0; bus.i_cache_wb_dat_nxt = 32'h0;
    bus.i_cache_wb_cti_nxt = 3'b111;
    bus.i_wb_ack = 1'b0; bus.i_wb_dat = 32'h0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    clear_inputs();
    bus.i_tlb_wb_cyc_nxt = 1'b1;
    repeat (2) tick();
    checks++; if (bus.o_wb_cyc !== 1'b0) begin errors++; $display("FAIL reset_cyc: got %0h want 0", bus.o_wb_cyc); end
    checks++; if (bus.o_wb_stb !== 1'b0) begin errors++; $display("FAIL reset_stb: got %0h want 0", bus.o_wb_stb); end
    checks++; if (bus.o_wb_wen !== 1'b0) begin errors++; $display("FAIL reset_wen: got %0h want 0", bus.o_wb_wen); end
    checks++; if (bus.o_wb_adr !== 32'h0) begin errors++; $display("FAIL reset_adr: got %h want 0", bus.o_wb_adr); end
    checks++; if (bus.o_wb_dat !== 32'h0) begin errors++; $display("FAIL reset_dat: got %h want 0", bus.o_wb_dat); end
    checks++; if (bus.o_wb_sel !== 4'h0) begin errors++; $display("FAIL reset_sel: got %h want 0", bus.o_wb_sel); end
    checks++; if (bus.o_wb_cti !== 3'b111) begin errors++; $display("FAIL reset_cti: got %b want 111", bus.o_wb_cti); end
    checks++; if (bus.o_owner !== 2'b00) begin errors++; $display("FAIL reset_owner: got %b want 00", bus.o_owner); end
    checks++; if (dut.fair_cnt_r !== 4'd0) begin errors++; $display("FAIL reset_cnt: got %0d want 0", dut.fair_cnt_r); end
    bus.i_tlb_wb_cyc_nxt = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    tick();
    checks++; if (bus.o_owner !== 2'b00) begin errors++; $display("FAIL post_reset_owner: got %b want 00", bus.o_owner); end
  endtask

  task automatic test_tlb_only;
    bus.i_tlb_wb_cyc_nxt = 1'b1; bus.i_tlb_wb_stb_nxt = 1'b1; bus.i_tlb_wb_wen_nxt = 1'b1;
    bus.i_tlb_wb_adr_nxt = 32'h0000_4000; bus.i_tlb_wb_sel_nxt = 4'hf; bus.i_tlb_wb_dat_nxt = 32'h1234_5678;
    bus.i_cache_wb_cti_nxt = 3'b010;
    tick();
    checks++; if (bus.o_wb_cyc !== 1'b1) begin errors++; $display("FAIL tlb_cyc: got %0h want 1", bus.o_wb_cyc); end
    checks++; if (bus.o_wb_stb !== 1'b1) begin errors++; $display("FAIL tlb_stb: got %0h want 1", bus.o_wb_stb); end
    checks++; if (bus.o_wb_wen !== 1'b1) begin errors++; $display("FAIL tlb_wen: got %0h want 1", bus.o_wb_wen); end
    checks++; if (bus.o_wb_adr !== 32'h0000_4000) begin errors++; $display("FAIL tlb_adr: got %h want 00004000", bus.o_wb_adr); end
    checks++; if (bus.o_wb_sel !== 4'hf) begin errors++; $display("FAIL tlb_sel: got %h want f", bus.o_wb_sel); end
    checks++; if (bus.o_wb_dat !== 32'h1234_5678) begin errors++; $display("FAIL tlb_dat: got %h want 12345678", bus.o_wb_dat); end
    checks++; if (bus.o_wb_cti !== 3'b111) begin errors++; $display("FAIL tlb_cti: got %b want 111", bus.o_wb_cti); end
    checks++; if (bus.o_owner !== 2'b01) begin errors++; $display("FAIL tlb_owner: got %b want 01", bus.o_owner); end
    bus.i_wb_ack = 1'b1; bus.i_wb_dat = 32'hdead_beef;
    #1;
    checks++; if (bus.o_tlb_wb_ack !== 1'b1) begin errors++; $display("FAIL tlb_ack: got %0h want 1", bus.o_tlb_wb_ack); end
    checks++; if (bus.o_cache_wb_ack !== 1'b0) begin errors++; $display("FAIL tlb_cache_ack: got %0h want 0", bus.o_cache_wb_ack); end
    checks++; if (bus.o_tlb_wb_dat !== 32'hdead_beef) begin errors++; $display("FAIL tlb_rdat: got %h want deadbeef", bus.o_tlb_wb_dat); end
    checks++; if (bus.o_cache_wb_dat !== 32'hdead_beef) begin errors++; $display("FAIL cache_rdat: got %h want deadbeef", bus.o_cache_wb_dat); end
    // owner keeps cyc but drops stb: ack must not be routed
    bus.i_wb_ack = 1'b0; bus.i_tlb_wb_stb_nxt = 1'b0;
    tick();
    checks++; if ({bus.o_owner, bus.o_wb_stb} !== 3'b010) begin errors++; $display("FAIL tlb_nostb: got %b want 010", {bus.o_owner, bus.o_wb_stb}); end
    bus.i_wb_ack = 1'b1;
    #1;
    checks++; if (bus.o_tlb_wb_ack !== 1'b0) begin errors++; $display("FAIL tlb_ack_nostb: got %0h want 0", bus.o_tlb_wb_ack); end
    bus.i_wb_ack = 1'b0; bus.i_tlb_wb_cyc_nxt = 1'b0;
    tick();
    checks++; if ({bus.o_wb_cyc, bus.o_wb_stb, bus.o_wb_wen} !== 3'b000) begin errors++; $display("FAIL rel_ctrl: got %b want 000", {bus.o_wb_cyc, bus.o_wb_stb, bus.o_wb_wen}); end
    checks++; if (bus.o_wb_sel !== 4'h0) begin errors++; $display("FAIL rel_sel: got %h want 0", bus.o_wb_sel); end
    checks++; if (bus.o_wb_cti !== 3'b111) begin errors++; $display("FAIL rel_cti: got %b want 111", bus.o_wb_cti); end
    checks++; if (bus.o_wb_adr !== 32'h0000_4000) begin errors++; $display("FAIL rel_adr_hold: got %h want 00004000", bus.o_wb_adr); end
    checks++; if (bus.o_wb_dat !== 32'h1234_5678) begin errors++; $display("FAIL rel_dat_hold: got %h want 12345678", bus.o_wb_dat); end
    checks++; if (bus.o_owner !== 2'b00) begin errors++; $display("FAIL rel_owner: got %b want 00", bus.o_owner); end
    bus.i_wb_ack = 1'b1;
    #1;
    checks++; if ({bus.o_tlb_wb_ack, bus.o_cache_wb_ack} !== 2'b00) begin errors++; $display("FAIL idle_ack: got %b want 00", {bus.o_tlb_wb_ack, bus.o_cache_wb_ack}); end
    clear_inputs();
  endtask

  task automatic test_cache_burst;
    logic [2:0] cti_tab [4];
    int pulses;
    cti_tab = '{3'b010, 3'b010, 3'b010, 3'b111};
    pulses = 0;
    for (int b = 0; b < 4; b++) begin
      bus.i_cache_wb_cyc_nxt = 1'b1; bus.i_cache_wb_stb_nxt = 1'b1; bus.i_cache_wb_sel_nxt = 4'hf;
      bus.i_cache_wb_adr_nxt = 32'h0000_8000 + 32'(b * 4);
      bus.i_cache_wb_cti_nxt = cti_tab[b];
      bus.i_wb_ack = 1'b0;
      tick();
      checks++; if (bus.o_wb_cti !== cti_tab[b]) begin errors++; $display("FAIL burst_cti[%0d]: got %b want %b", b, bus.o_wb_cti, cti_tab[b]); end
      checks++; if (bus.o_wb_adr !== 32'h0000_8000 + 32'(b * 4)) begin errors++; $display("FAIL burst_adr[%0d]: got %h want %h", b, bus.o_wb_adr, 32'h0000_8000 + 32'(b * 4)); end
      checks++; if (bus.o_owner !== 2'b10) begin errors++; $display("FAIL burst_owner[%0d]: got %b want 10", b, bus.o_owner); end
      bus.i_wb_ack = 1'b1;
      #1;
      if (bus.o_cache_wb_ack === 1'b1) pulses++;
      checks++; if (bus.o_tlb_wb_ack !== 1'b0) begin errors++; $display("FAIL burst_tlb_ack[%0d]: got %0h want 0", b, bus.o_tlb_wb_ack); end
    end
    bus.i_wb_ack = 1'b0; bus.i_cache_wb_cyc_nxt = 1'b0; bus.i_cache_wb_stb_nxt = 1'b0;
    tick();
    checks++; if (pulses != 4) begin errors++; $display("FAIL burst_acks: got %0d want 4", pulses); end
    checks++; if ({bus.o_wb_cyc, bus.o_owner} !== 3'b000) begin errors++; $display("FAIL burst_end: got %b want 000", {bus.o_wb_cyc, bus.o_owner}); end
    clear_inputs();
  endtask

  task automatic test_contention;
    logic [1:0] exp_owner [10];
    exp_owner = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b01, 2'b01, 2'b01, 2'b01, 2'b10};
    bus.i_tlb_wb_adr_nxt = 32'h0000_1000; bus.i_cache_wb_adr_nxt = 32'h0000_2000;
    for (int i = 0; i < 10; i++) begin
      bus.i_tlb_wb_cyc_nxt = 1'b1; bus.i_tlb_wb_stb_nxt = 1'b1;
      bus.i_cache_wb_cyc_nxt = 1'b1; bus.i_cache_wb_stb_nxt = 1'b1;
      tick();
      checks++; if (bus.o_owner !== exp_owner[i]) begin errors++; $display("FAIL grant[%0d]: got %b want %b", i, bus.o_owner, exp_owner[i]); end
      checks++; if (bus.o_wb_adr !== ((exp_owner[i] == 2'b01) ? 32'h0000_1000 : 32'h0000_2000)) begin errors++; $display("FAIL grant_adr[%0d]: got %h", i, bus.o_wb_adr); end
      bus.i_wb_ack = 1'b1;
      #1;
      checks++; if ({bus.o_tlb_wb_ack, bus.o_cache_wb_ack} !== ((exp_owner[i] == 2'b01) ? 2'b10 : 2'b01)) begin errors++; $display("FAIL grant_ack[%0d]: got %b", i, {bus.o_tlb_wb_ack, bus.o_cache_wb_ack}); end
      bus.i_wb_ack = 1'b0;
      if (exp_owner[i] == 2'b01) begin
        bus.i_tlb_wb_cyc_nxt = 1'b0; bus.i_tlb_wb_stb_nxt = 1'b0;
      end else begin
        bus.i_cache_wb_cyc_nxt = 1'b0; bus.i_cache_wb_stb_nxt = 1'b0;
      end
      tick();
      checks++; if ({bus.o_wb_cyc, bus.o_owner} !== 3'b000) begin errors++; $display("FAIL gap[%0d]: got %b want 000", i, {bus.o_wb_cyc, bus.o_owner}); end
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_cache_hold;
    bus.i_cache_wb_cyc_nxt = 1'b1; bus.i_cache_wb_stb_nxt = 1'b1; bus.i_cache_wb_adr_nxt = 32'h0000_9000;
    bus.i_cache_wb_cti_nxt = 3'b010;
    tick();
    checks++; if (bus.o_owner !== 2'b10) begin errors++; $display("FAIL hold_grant: got %b want 10", bus.o_owner); end
    bus.i_tlb_wb_cyc_nxt = 1'b1; bus.i_tlb_wb_stb_nxt = 1'b1; bus.i_tlb_wb_adr_nxt = 32'h0000_5000;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++; if ({bus.o_owner, bus.o_wb_adr} !== {2'b10, 32'h0000_9000}) begin errors++; $display("FAIL hold_owner[%0d]: got %b/%h want 10/00009000", k, bus.o_owner, bus.o_wb_adr); end
      bus.i_wb_ack = 1'b1;
      #1;
      checks++; if ({bus.o_tlb_wb_ack, bus.o_cache_wb_ack} !== 2'b01) begin errors++; $display("FAIL hold_ack[%0d]: got %b want 01", k, {bus.o_tlb_wb_ack, bus.o_cache_wb_ack}); end
      bus.i_wb_ack = 1'b0;
    end
    bus.i_cache_wb_cyc_nxt = 1'b0; bus.i_cache_wb_stb_nxt = 1'b0;
    tick();
    checks++; if ({bus.o_wb_cyc, bus.o_owner} !== 3'b000) begin errors++; $display("FAIL hold_gap: got %b want 000", {bus.o_wb_cyc, bus.o_owner}); end
    tick();
    checks++; if ({bus.o_wb_cyc, bus.o_owner} !== 3'b101) begin errors++; $display("FAIL hold_tlb: got %b want 101", {bus.o_wb_cyc, bus.o_owner}); end
    checks++; if (bus.o_wb_adr !== 32'h0000_5000) begin errors++; $display("FAIL hold_tlb_adr: got %h want 00005000", bus.o_wb_adr); end
  endtask

  task automatic test_reset_mid;
    bus.i_tlb_wb_cyc_nxt = 1'b0; bus.i_tlb_wb_stb_nxt = 1'b0;
    tick();
    bus.i_tlb_wb_cyc_nxt = 1'b1; bus.i_tlb_wb_stb_nxt = 1'b1;
    bus.i_cache_wb_cyc_nxt = 1'b1; bus.i_cache_wb_stb_nxt = 1'b1;
    tick();
    checks++; if (bus.o_owner !== 2'b01) begin errors++; $display("FAIL mid_grant: got %b want 01", bus.o_owner); end
    checks++; if (dut.fair_cnt_r !== 4'd1) begin errors++; $display("FAIL mid_cnt: got %0d want 1", dut.fair_cnt_r); end
    #2;
    rst = 1'b1;
    #1;
    checks++; if ({bus.o_wb_cyc, bus.o_wb_stb, bus.o_owner} !== 4'b0000) begin errors++; $display("FAIL mid_abort: got %b want 0000", {bus.o_wb_cyc, bus.o_wb_stb, bus.o_owner}); end
    checks++; if (dut.fair_cnt_r !== 4'd0) begin errors++; $display("FAIL mid_cnt_clr: got %0d want 0", dut.fair_cnt_r); end
    bus.i_tlb_wb_cyc_nxt = 1'b0; bus.i_tlb_wb_stb_nxt = 1'b0;
    bus.i_cache_wb_adr_nxt = 32'h0000_a000;
    tick();
    checks++; if (bus.o_owner !== 2'b00) begin errors++; $display("FAIL mid_held: got %b want 00", bus.o_owner); end
    @(negedge clk);
    rst = 1'b0;
    tick();
    checks++; if ({bus.o_wb_cyc, bus.o_owner} !== 3'b110) begin errors++; $display("FAIL mid_regrant: got %b want 110", {bus.o_wb_cyc, bus.o_owner}); end
    checks++; if (bus.o_wb_adr !== 32'h0000_a000) begin errors++; $display("FAIL mid_regrant_adr: got %h want 0000a000", bus.o_wb_adr); end
  endtask

  initial begin
    test_reset();
    test_tlb_only();
    test_cache_burst();
    test_contention();
    test_cache_hold();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
